avalon_sram_tester: RTL and testbench



---
 rtl/sram_test_pkg.sv | 40 ++++
 rtl/avalon_sram_tester_if.sv | 22 ++
 rtl/sram_test_checker.sv | 75 +++++++
 rtl/avalon_sram_tester.sv | 175 +++++++++++++++++
 tb/tb_avalon_sram_tester.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_test_pkg.sv
// Shared types, constants and the test-pattern generator for the Avalon SRAM tester.
package sram_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    PAT_ADDR        = 2'd0,
    PAT_INV_ADDR    = 2'd1,
    PAT_CHECKER     = 2'd2,
    PAT_INV_CHECKER = 2'd3
  } pattern_e;

  localparam int unsigned MAX_W = 64;

  localparam logic [MAX_W-1:0] CHECKER_EVEN = 64'h5555_5555_5555_5555;
  localparam logic [MAX_W-1:0] CHECKER_ODD  = 64'hAAAA_AAAA_AAAA_AAAA;

  // aw limits ~address to the real address width so wide data words are zero-extended.
  function automatic logic [MAX_W-1:0] expected_data(input logic [MAX_W-1:0] addr,
                                                     input pattern_e pattern,
                                                     input int unsigned aw = MAX_W);
    logic [MAX_W-1:0] mask;
    mask = '1;
    mask = mask >> (MAX_W - aw);
    unique case (pattern)
      PAT_ADDR:        return addr;
      PAT_INV_ADDR:    return ~addr & mask;
      PAT_CHECKER:     return addr[0] ? CHECKER_ODD : CHECKER_EVEN;
      PAT_INV_CHECKER: return addr[0] ? CHECKER_EVEN : CHECKER_ODD;
      default:         return '0;
    endcase
  endfunction

endpackage

// File: rtl/avalon_sram_tester_if.sv
// Avalon-MM request/response bundle between the tester (master) and the SRAM controller (slave).
interface avalon_sram_tester_if #(
  parameter int AW = 19,
  parameter int DW = 16
);
  logic            avs_read;
  logic            avs_write;
  logic [AW-1:0]   avs_address;
  logic [DW-1:0]   avs_writedata;
  logic [DW/8-1:0] avs_byteenable;
  logic [DW-1:0]   avs_readdata;

  modport master (
    output avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
    input  avs_readdata
  );

  modport slave (
    input  avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
    output avs_readdata
  );
endinterface

// File: rtl/sram_test_checker.sv
// Read-latency delay line, read-data comparator, saturating error counter and first-error capture.
module sram_test_checker #(
  parameter int READ_LATENCY = 1,
  parameter int AVS_AW       = 19,
  parameter int AVS_DW       = 16,
  parameter int ERR_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              issue_vld_i,
  input  logic [AVS_DW-1:0] issue_exp_i,
  input  logic [AVS_AW-1:0] issue_addr_i,
  input  logic [AVS_DW-1:0] rdata_i,
  output logic [ERR_W-1:0]  err_count_o,
  output logic [AVS_AW-1:0] first_err_addr_o,
  output logic              clean_next_o
);

  logic [READ_LATENCY-1:0] vld_q;
  logic [AVS_DW-1:0]       exp_q [READ_LATENCY];
  logic [AVS_AW-1:0]       adr_q [READ_LATENCY];

  logic [ERR_W-1:0]  err_q, err_d;
  logic [AVS_AW-1:0] first_q, first_d;
  logic              mismatch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        exp_q[i] <= '0;
        adr_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= issue_vld_i;
      exp_q[0] <= issue_exp_i;
      adr_q[0] <= issue_addr_i;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
        adr_q[i] <= adr_q[i-1];
      end
    end
  end

  assign mismatch = vld_q[READ_LATENCY-1] && (rdata_i != exp_q[READ_LATENCY-1]);

  always_comb begin
    err_d   = err_q;
    first_d = first_q;
    if (clr_i) begin
      err_d   = '0;
      first_d = '0;
    end else if (mismatch) begin
      if (err_q != '1) err_d = err_q + ERR_W'(1);
      if (err_q == '0) first_d = adr_q[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q   <= '0;
      first_q <= '0;
    end else begin
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;
  assign clean_next_o     = (err_d == '0);

endmodule

// File: rtl/avalon_sram_tester.sv
// Built-in SRAM test master: writes a pattern over [lo..hi], reads it back and reports mismatches.
module avalon_sram_tester
  import sram_test_pkg::*;
#(
  parameter int AVS_AW       = 19,
  parameter int AVS_DW       = 16,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [1:0]          pattern_sel,
  input  logic [AVS_AW-1:0]   addr_lo,
  input  logic [AVS_AW-1:0]   addr_hi,
  avalon_sram_tester_if.master avs,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [AVS_AW-1:0]   first_err_addr
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

  state_e            state_q, state_d;
  logic [AVS_AW-1:0] cur_q, cur_d;
  logic [AVS_AW-1:0] lo_q, lo_d;
  logic [AVS_AW-1:0] hi_q, hi_d;
  pattern_e          pat_q, pat_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [AVS_DW-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              clr;
  logic              clean_next;

  function automatic logic [AVS_DW-1:0] pattern_word(input logic [AVS_AW-1:0] a,
                                                     input pattern_e p);
    return AVS_DW'(expected_data(MAX_W'(a), p, AVS_AW));
  endfunction

  // Bus flops are loaded with the request for the next cycle, so the
  // current address is what the bus shows and cur==hi ends a phase.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    pat_d   = pat_q;
    read_d  = 1'b0;
    write_d = 1'b0;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d   = addr_lo;
          hi_d   = addr_hi;
          pat_d  = pattern_e'(pattern_sel);
          clr    = 1'b1;
          pass_d = 1'b0;
          if (addr_hi < addr_lo) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_WRITE;
            write_d = 1'b1;
            cur_d   = addr_lo;
            wdata_d = pattern_word(addr_lo, pattern_e'(pattern_sel));
          end
        end
      end
      S_WRITE: begin
        if (cur_q == hi_q) begin
          state_d = S_READ;
          read_d  = 1'b1;
          cur_d   = lo_q;
        end else begin
          write_d = 1'b1;
          cur_d   = cur_q + AVS_AW'(1);
          wdata_d = pattern_word(cur_q + AVS_AW'(1), pat_q);
        end
      end
      S_READ: begin
        if (cur_q == hi_q) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          read_d = 1'b1;
          cur_d  = cur_q + AVS_AW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = clean_next;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      pat_q   <= PAT_ADDR;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      pat_q   <= pat_d;
      read_q  <= read_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  sram_test_checker #(
    .READ_LATENCY (READ_LATENCY),
    .AVS_AW       (AVS_AW),
    .AVS_DW       (AVS_DW),
    .ERR_W        (ERR_W)
  ) u_checker (
    .clk              (clk),
    .reset_n          (reset_n),
    .clr_i            (clr),
    .issue_vld_i      (read_q),
    .issue_exp_i      (pattern_word(cur_q, pat_q)),
    .issue_addr_i     (cur_q),
    .rdata_i          (avs.avs_readdata),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr),
    .clean_next_o     (clean_next)
  );

  assign avs.avs_read       = read_q;
  assign avs.avs_write      = write_q;
  assign avs.avs_address    = cur_q;
  assign avs.avs_writedata  = wdata_q;
  assign avs.avs_byteenable = '1;

  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_avalon_sram_tester.sv
// Directed bench: default-parameter tester on a simple memory model, plus a small
// latency-3 / 4-bit-counter instance for latency alignment and error saturation.
module tb_avalon_sram_tester;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_pat(input longint unsigned a, input int unsigned aw,
                                            input int unsigned pat);
    longint unsigned m;
    case (pat)
      0: m = a;
      1: m = a ^ ((64'd1 << aw) - 1);
      2: m = a[0] ? 64'hAAAA : 64'h5555;
      default: m = a[0] ? 64'h5555 : 64'hAAAA;
    endcase
    return m[15:0];
  endfunction

  // ---------------- DUT1: default parameters, L=1 ----------------
  logic        start1 = 1'b0;
  logic [1:0]  pat1 = '0;
  logic [18:0] lo1 = '0, hi1 = '0;
  logic        busy1, done1, pass1;
  logic [15:0] err1;
  logic [18:0] ferr1;
  int          fault_mode = 0;
  logic [15:0] mem1 [256];

  avalon_sram_tester_if #(.AW(19), .DW(16)) bus1 ();

  avalon_sram_tester dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .pattern_sel(pat1),
    .addr_lo(lo1), .addr_hi(hi1), .avs(bus1.master),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_addr(ferr1)
  );

  always @(posedge clk) begin
    if (bus1.avs_write) mem1[bus1.avs_address[7:0]] <= bus1.avs_writedata;
    if (bus1.avs_read) begin
      if (fault_mode == 1 && bus1.avs_address == 19'h0C)
        bus1.avs_readdata <= mem1[bus1.avs_address[7:0]] & 16'hFFF7;
      else
        bus1.avs_readdata <= mem1[bus1.avs_address[7:0]];
    end
  end

  int r_done_cyc, r_ndone, r_nwr, r_nrd, r_wr_first, r_wr_last, r_rd_first, r_rd_last;
  int r_busy_first, r_busy_last, r_bad;
  logic        r_pass, r_pass_hold;
  logic [15:0] r_err, r_err_hold;
  logic [18:0] r_ferr;

  task automatic run1(input int unsigned lo, input int unsigned hi, input int unsigned pat);
    int unsigned n, limit, ewa, era;
    n = (hi >= lo) ? hi - lo + 1 : 0;
    limit = 2 * n + 10;
    ewa = lo;
    era = lo;
    r_done_cyc = -1; r_ndone = 0; r_nwr = 0; r_nrd = 0; r_bad = 0;
    r_wr_first = -1; r_wr_last = -1; r_rd_first = -1; r_rd_last = -1;
    r_busy_first = -1; r_busy_last = -1;
    r_pass = 1'bx; r_err = 'x; r_ferr = 'x;
    @(posedge clk); #1;
    lo1 = lo[18:0]; hi1 = hi[18:0]; pat1 = pat[1:0]; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int c = 1; c <= int'(limit); c++) begin
      @(negedge clk);
      if (bus1.avs_write) begin
        if (r_nwr == 0) r_wr_first = c;
        r_wr_last = c;
        if (int'(bus1.avs_address) != int'(ewa)) r_bad++;
        if (bus1.avs_writedata !== model_pat(ewa, 19, pat)) r_bad++;
        if (bus1.avs_byteenable !== 2'b11) r_bad++;
        ewa++;
        r_nwr++;
      end
      if (bus1.avs_read) begin
        if (r_nrd == 0) r_rd_first = c;
        r_rd_last = c;
        if (int'(bus1.avs_address) != int'(era)) r_bad++;
        era++;
        r_nrd++;
      end
      if (bus1.avs_read && bus1.avs_write) r_bad++;
      if (busy1) begin
        if (r_busy_first < 0) r_busy_first = c;
        r_busy_last = c;
      end
      if (done1) begin
        if (r_ndone == 0) begin
          r_done_cyc = c;
          r_pass = pass1;
          r_err = err1;
          r_ferr = ferr1;
        end
        r_ndone++;
      end
    end
    r_pass_hold = pass1;
    r_err_hold = err1;
  endtask

  // ---------------- DUT2: AW=8, L=3, ERR_W=4 ----------------
  logic        start2 = 1'b0;
  logic [1:0]  pat2 = '0;
  logic [7:0]  lo2 = '0, hi2 = '0;
  logic        busy2, done2, pass2;
  logic [3:0]  err2;
  logic [7:0]  ferr2;
  logic        stuck2 = 1'b0;
  logic [15:0] mem2 [256];
  logic [15:0] p1, p2;

  avalon_sram_tester_if #(.AW(8), .DW(16)) bus2 ();

  avalon_sram_tester #(
    .AVS_AW(8), .AVS_DW(16), .READ_LATENCY(3), .ERR_W(4)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .pattern_sel(pat2),
    .addr_lo(lo2), .addr_hi(hi2), .avs(bus2.master),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_addr(ferr2)
  );

  always @(posedge clk) begin
    if (bus2.avs_write) mem2[bus2.avs_address] <= bus2.avs_writedata;
    p1 <= stuck2 ? 16'hFFFF : (bus2.avs_read ? mem2[bus2.avs_address] : 16'h1234);
    p2 <= p1;
    bus2.avs_readdata <= p2;
  end

  int          q_done_cyc;
  logic        q_pass;
  logic [3:0]  q_err;
  logic [7:0]  q_ferr;

  task automatic run2(input int unsigned lo, input int unsigned hi, input int unsigned pat);
    q_done_cyc = -1; q_pass = 1'bx; q_err = 'x; q_ferr = 'x;
    @(posedge clk); #1;
    lo2 = lo[7:0]; hi2 = hi[7:0]; pat2 = pat[1:0]; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (done2) begin
        q_done_cyc = c;
        q_pass = pass2;
        q_err = err2;
        q_ferr = ferr2;
        break;
      end
    end
  endtask

  int ndone_rst;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_pass", pass1, 1'b0);
    check("rst_err", err1, 16'h0);
    check("rst_ferr", ferr1, 19'h0);
    check("rst_bus", {bus1.avs_read, bus1.avs_write}, 2'b00);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Clean pass, lo=0 hi=3, address pattern
    run1(0, 3, 0);
    check("clean_wr_first", r_wr_first, 1);
    check("clean_wr_last", r_wr_last, 4);
    check("clean_nwr", r_nwr, 4);
    check("clean_rd_first", r_rd_first, 5);
    check("clean_rd_last", r_rd_last, 8);
    check("clean_nrd", r_nrd, 4);
    check("clean_done_cyc", r_done_cyc, 10);
    check("clean_ndone", r_ndone, 1);
    check("clean_busy_first", r_busy_first, 1);
    check("clean_busy_last", r_busy_last, 10);
    check("clean_bus_bad", r_bad, 0);
    check("clean_pass", r_pass, 1'b1);
    check("clean_err", r_err, 16'h0);
    check("clean_ferr", r_ferr, 19'h0);

    // Checkerboard patterns over an odd-aligned range
    run1(3, 8, 2);
    check("chk_bus_bad", r_bad, 0);
    check("chk_done_cyc", r_done_cyc, 14);
    check("chk_pass", r_pass, 1'b1);
    run1(3, 8, 3);
    check("ichk_bus_bad", r_bad, 0);
    check("ichk_pass", r_pass, 1'b1);
    run1(16, 20, 1);
    check("inv_bus_bad", r_bad, 0);
    check("inv_pass", r_pass, 1'b1);

    // Single fault at 0x0C
    fault_mode = 1;
    run1(0, 15, 0);
    fault_mode = 0;
    check("fault_done_cyc", r_done_cyc, 34);
    check("fault_err", r_err, 16'd1);
    check("fault_ferr", r_ferr, 19'h0C);
    check("fault_pass", r_pass, 1'b0);
    check("fault_err_hold", r_err_hold, 16'd1);
    check("fault_pass_hold", r_pass_hold, 1'b0);

    // Empty range
    run1(5, 2, 0);
    check("empty_nwr", r_nwr, 0);
    check("empty_nrd", r_nrd, 0);
    check("empty_done_cyc", r_done_cyc, 1);
    check("empty_busy_first", r_busy_first, 1);
    check("empty_busy_last", r_busy_last, 1);
    check("empty_pass", r_pass, 1'b1);
    check("empty_err", r_err, 16'h0);

    // Top of address space, inverted address pattern
    run1(19'h7FFFF, 19'h7FFFF, 1);
    check("top_nwr", r_nwr, 1);
    check("top_nrd", r_nrd, 1);
    check("top_done_cyc", r_done_cyc, 4);
    check("top_ndone", r_ndone, 1);
    check("top_bus_bad", r_bad, 0);
    check("top_pass", r_pass, 1'b1);

    // Reset during READ
    @(posedge clk); #1;
    lo1 = '0; hi1 = 19'd3; pat1 = 2'd0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_in_read", bus1.avs_read, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_read", bus1.avs_read, 1'b0);
    check("mid_rst_write", bus1.avs_write, 1'b0);
    check("mid_rst_busy", busy1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ndone_rst = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done1) ndone_rst++;
    end
    check("mid_no_done", ndone_rst, 0);
    run1(0, 3, 0);
    check("post_rst_done_cyc", r_done_cyc, 10);
    check("post_rst_rd_first", r_rd_first, 5);
    check("post_rst_pass", r_pass, 1'b1);

    // Latency-3 instance: clean run, then stuck readdata saturating a 4-bit counter
    run2(8'h10, 8'h13, 1);
    check("l3_done_cyc", q_done_cyc, 12);
    check("l3_pass", q_pass, 1'b1);
    check("l3_err", q_err, 4'h0);
    stuck2 = 1'b1;
    run2(8'h00, 8'h1F, 0);
    stuck2 = 1'b0;
    check("sat_done_cyc", q_done_cyc, 68);
    check("sat_err", q_err, 4'hF);
    check("sat_ferr", q_ferr, 8'h00);
    check("sat_pass", q_pass, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
